// File: rtl/calc_pkg.sv
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared state, operator and key-class encodings for calc_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_pkg;

  typedef enum logic [2:0] {
    S_A   = 3'd0,
    S_OP  = 3'd1,
    S_B   = 3'd2,
    S_RES = 3'd3,
    S_ERR = 3'd4
  } state_t;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;

  typedef enum logic [1:0] {
    KC_NONE = 2'd0,
    KC_NUM  = 2'd1,
    KC_OP   = 2'd2,
    KC_EQ   = 2'd3
  } key_class_t;

  // Largest magnitude representable with ndig decimal digits.
  function automatic int calc_maxv(input int ndig);
    int v;
    v = 1;
    for (int i = 0; i < ndig; i++) v = v * 10;
    return v - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/calc_if.sv
// ============================================================================
// Module   : calc_if
// Purpose  : Keypad event inputs and display outputs of the calculator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface calc_if #(
  parameter int W = 16
);
  logic         key_valid;
  logic         is_number;
  logic         is_op;
  logic         is_eq;
  logic [3:0]   num_val;
  logic [1:0]   op_val;
  logic [W-2:0] disp_mag;
  logic         disp_neg;
  logic         err;
  logic [1:0]   op_pending;
  logic [2:0]   state_dbg;

  modport master (
    output key_valid, is_number, is_op, is_eq, num_val, op_val,
    input  disp_mag, disp_neg, err, op_pending, state_dbg
  );

  modport slave (
    input  key_valid, is_number, is_op, is_eq, num_val, op_val,
    output disp_mag, disp_neg, err, op_pending, state_dbg
  );
endinterface

`default_nettype wire

// File: rtl/calc_ctrl_key_event.sv
// ============================================================================
// Module   : key_event
// Purpose  : Rising-edge detect, priority classify and one-cycle key event.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_event
  import calc_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       key_valid_i,
  input  wire logic       is_number_i,
  input  wire logic       is_op_i,
  input  wire logic       is_eq_i,
  input  wire logic [3:0] num_val_i,
  input  wire logic [1:0] op_val_i,
  output logic            ev_valid_o,
  output key_class_t      ev_class_o,
  output logic [3:0]      ev_val_o
);

  logic       kv_q;
  logic       ev_valid_q, ev_valid_d;
  key_class_t class_q, class_d;
  logic [3:0] val_q, val_d;

  always_comb begin
    ev_valid_d = 1'b0;
    class_d    = KC_NONE;
    val_d      = 4'd0;
    if (key_valid_i && !kv_q) begin
      if (is_number_i) begin
        if (num_val_i <= 4'd9) begin
          ev_valid_d = 1'b1;
          class_d    = KC_NUM;
          val_d      = num_val_i;
        end
      end else if (is_op_i) begin
        if (op_val_i == OP_ADD || op_val_i == OP_SUB) begin
          ev_valid_d = 1'b1;
          class_d    = KC_OP;
          val_d      = {2'b00, op_val_i};
        end
      end else if (is_eq_i) begin
        ev_valid_d = 1'b1;
        class_d    = KC_EQ;
      end
    end
  end

  // Edge register resets high so a key held through reset is not an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      kv_q       <= 1'b1;
      ev_valid_q <= 1'b0;
      class_q    <= KC_NONE;
      val_q      <= 4'd0;
    end else begin
      kv_q       <= key_valid_i;
      ev_valid_q <= ev_valid_d;
      class_q    <= class_d;
      val_q      <= val_d;
    end
  end

  assign ev_valid_o = ev_valid_q;
  assign ev_class_o = class_q;
  assign ev_val_o   = val_q;

endmodule

`default_nettype wire

// File: rtl/calc_ctrl.sv
// ============================================================================
// Module   : calc_ctrl
// Purpose  : Calculator sequencer: operand entry, signed add/sub, display.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_ctrl
  import calc_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int W    = 16
) (
  input  wire logic clk,
  input  wire logic reset,
  calc_if.slave     bus
);

  localparam int                  CW     = $clog2(NDIG + 1);
  localparam logic [CW-1:0]       c_NDIG = CW'(NDIG);
  localparam logic signed [W-1:0] c_MAXV = W'(calc_maxv(NDIG));

  logic       ev_valid;
  key_class_t ev_class;
  logic [3:0] ev_val;

  key_event u_key_event (
    .clk         (clk),
    .reset       (reset),
    .key_valid_i (bus.key_valid),
    .is_number_i (bus.is_number),
    .is_op_i     (bus.is_op),
    .is_eq_i     (bus.is_eq),
    .num_val_i   (bus.num_val),
    .op_val_i    (bus.op_val),
    .ev_valid_o  (ev_valid),
    .ev_class_o  (ev_class),
    .ev_val_o    (ev_val)
  );

  state_t              state_q, state_d;
  logic signed [W-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [W-2:0]        mag_q, mag_d;
  logic                neg_q, neg_d, err_q, err_d;

  logic signed [W-1:0] w_digit, w_acc_a, w_acc_b, w_res, w_disp, w_abs;
  logic                w_res_ok, w_cnt_ok;
  logic [1:0]          w_evop;

  assign w_digit  = $signed({{(W-4){1'b0}}, ev_val});
  assign w_acc_a  = (a_q <<< 3) + (a_q <<< 1) + w_digit;
  assign w_acc_b  = (b_q <<< 3) + (b_q <<< 1) + w_digit;
  assign w_res    = (op_q == OP_SUB) ? (a_q - b_q) : (a_q + b_q);
  assign w_res_ok = (w_res <= c_MAXV) && (w_res >= -c_MAXV);
  assign w_cnt_ok = (cnt_q < c_NDIG);
  assign w_evop   = ev_val[1:0];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    if (ev_valid) begin
      case (state_q)
        S_A: begin
          if (ev_class == KC_NUM && w_cnt_ok) begin
            a_d   = w_acc_a;
            cnt_d = cnt_q + CW'(1);
          end else if (ev_class == KC_OP) begin
            op_d    = w_evop;
            cnt_d   = '0;
            state_d = S_OP;
          end
        end
        S_OP: begin
          if (ev_class == KC_NUM) begin
            b_d     = w_digit;
            cnt_d   = CW'(1);
            state_d = S_B;
          end else if (ev_class == KC_OP) begin
            op_d = w_evop;
          end
        end
        S_B: begin
          if (ev_class == KC_NUM && w_cnt_ok) begin
            b_d   = w_acc_b;
            cnt_d = cnt_q + CW'(1);
          end else if (ev_class == KC_OP) begin
            r_d = w_res;
            if (w_res_ok) begin
              a_d     = w_res;
              op_d    = w_evop;
              cnt_d   = '0;
              state_d = S_OP;
            end else begin
              state_d = S_ERR;
            end
          end else if (ev_class == KC_EQ) begin
            r_d     = w_res;
            state_d = w_res_ok ? S_RES : S_ERR;
          end
        end
        S_RES: begin
          if (ev_class == KC_NUM) begin
            a_d     = w_digit;
            b_d     = '0;
            cnt_d   = CW'(1);
            op_d    = OP_NONE;
            state_d = S_A;
          end else if (ev_class == KC_OP) begin
            a_d     = r_q;
            op_d    = w_evop;
            cnt_d   = '0;
            state_d = S_OP;
          end
        end
        S_ERR: begin
          if (ev_class == KC_EQ) begin
            a_d     = '0;
            b_d     = '0;
            r_d     = '0;
            cnt_d   = '0;
            op_d    = OP_NONE;
            state_d = S_A;
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  // Display follows the next state so it changes on the same edge as the FSM.
  always_comb begin
    w_disp = '0;
    case (state_d)
      S_A, S_OP: w_disp = a_d;
      S_B:       w_disp = b_d;
      S_RES:     w_disp = r_d;
      default:   w_disp = '0;
    endcase
    neg_d = (w_disp < 0);
    w_abs = neg_d ? -w_disp : w_disp;
    mag_d = w_abs[W-2:0];
    err_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      op_q    <= OP_NONE;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
    end
  end

  assign bus.disp_mag   = mag_q;
  assign bus.disp_neg   = neg_q;
  assign bus.err        = err_q;
  assign bus.op_pending = op_q;
  assign bus.state_dbg  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_calc_ctrl.sv
// ============================================================================
// Module   : tb_calc_ctrl
// Purpose  : Scoreboard bench for calc_ctrl key sequences and display output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_ctrl;

  logic clk;
  logic reset;
  int   cyc;
  int   ntot;
  int   nbad;

  typedef struct {
    logic [14:0] mag;
    logic        neg;
    logic        err;
    logic [2:0]  st;
    logic [1:0]  op;
    int          due;
    string       nm;
  } exp_t;

  exp_t sb[$];

  calc_if #(.W(16)) bus ();

  calc_ctrl #(.NDIG(4), .W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: each key's expected display is due two edges later.
  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      x = sb.pop_front();
      ntot++;
      if (bus.disp_mag !== x.mag || bus.disp_neg !== x.neg || bus.err !== x.err ||
          bus.state_dbg !== x.st || bus.op_pending !== x.op) begin
        nbad++;
        $display("FAIL %s: got mag=%0d neg=%0b err=%0b st=%0d op=%0d want mag=%0d neg=%0b err=%0b st=%0d op=%0d",
                 x.nm, bus.disp_mag, bus.disp_neg, bus.err, bus.state_dbg, bus.op_pending,
                 x.mag, x.neg, x.err, x.st, x.op);
      end
    end
  end

  task automatic press(input logic n, input logic o, input logic e,
                       input logic [3:0] nv, input logic [1:0] ov,
                       input logic [14:0] m, input logic ng,
                       input logic [2:0] s, input logic [1:0] op, input string nm);
    exp_t x;
    @(negedge clk);
    bus.is_number = n;
    bus.is_op     = o;
    bus.is_eq     = e;
    bus.num_val   = nv;
    bus.op_val    = ov;
    bus.key_valid = 1'b1;
    x.mag = m; x.neg = ng; x.err = (s == 3'd4); x.st = s; x.op = op;
    x.due = cyc + 2; x.nm = nm;
    sb.push_back(x);
    @(negedge clk);
    bus.key_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic dig(input logic [3:0] d, input logic [14:0] m, input logic ng,
                     input logic [2:0] s, input logic [1:0] op);
    press(1'b1, 1'b0, 1'b0, d, 2'd0, m, ng, s, op, "digit");
  endtask

  task automatic opk(input logic [1:0] v, input logic [14:0] m, input logic ng,
                     input logic [2:0] s, input logic [1:0] op);
    press(1'b0, 1'b1, 1'b0, 4'd0, v, m, ng, s, op, "operator");
  endtask

  task automatic eqk(input logic [14:0] m, input logic ng,
                     input logic [2:0] s, input logic [1:0] op);
    press(1'b0, 1'b0, 1'b1, 4'd0, 2'd0, m, ng, s, op, "equals");
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    ntot++;
    if (bus.disp_mag !== 15'd0 || bus.disp_neg !== 1'b0 || bus.err !== 1'b0 ||
        bus.op_pending !== 2'd0 || bus.state_dbg !== 3'd0) begin
      nbad++;
      $display("FAIL reset_state: got mag=%0d neg=%0b err=%0b op=%0d st=%0d want all 0",
               bus.disp_mag, bus.disp_neg, bus.err, bus.op_pending, bus.state_dbg);
    end
    reset = 1'b0;
  endtask

  task automatic test_add();
    do_reset();
    dig(4'd1, 15'd1,  1'b0, 3'd0, 2'd0);
    dig(4'd2, 15'd12, 1'b0, 3'd0, 2'd0);
    opk(2'd1, 15'd12, 1'b0, 3'd1, 2'd1);
    dig(4'd3, 15'd3,  1'b0, 3'd2, 2'd1);
    dig(4'd4, 15'd34, 1'b0, 3'd2, 2'd1);
    eqk(15'd46, 1'b0, 3'd3, 2'd1);
  endtask

  task automatic test_sub();
    do_reset();
    dig(4'd5, 15'd5, 1'b0, 3'd0, 2'd0);
    opk(2'd2, 15'd5, 1'b0, 3'd1, 2'd2);
    dig(4'd8, 15'd8, 1'b0, 3'd2, 2'd2);
    eqk(15'd3, 1'b1, 3'd3, 2'd2);
    opk(2'd1, 15'd3, 1'b1, 3'd1, 2'd1);
    dig(4'd4, 15'd4, 1'b0, 3'd2, 2'd1);
    eqk(15'd1, 1'b0, 3'd3, 2'd1);
  endtask

  task automatic test_ndig();
    do_reset();
    dig(4'd1, 15'd1,    1'b0, 3'd0, 2'd0);
    dig(4'd2, 15'd12,   1'b0, 3'd0, 2'd0);
    dig(4'd3, 15'd123,  1'b0, 3'd0, 2'd0);
    dig(4'd4, 15'd1234, 1'b0, 3'd0, 2'd0);
    dig(4'd5, 15'd1234, 1'b0, 3'd0, 2'd0);
  endtask

  task automatic test_chain();
    do_reset();
    dig(4'd2, 15'd2, 1'b0, 3'd0, 2'd0);
    opk(2'd1, 15'd2, 1'b0, 3'd1, 2'd1);
    dig(4'd3, 15'd3, 1'b0, 3'd2, 2'd1);
    opk(2'd1, 15'd5, 1'b0, 3'd1, 2'd1);
    dig(4'd4, 15'd4, 1'b0, 3'd2, 2'd1);
    eqk(15'd9, 1'b0, 3'd3, 2'd1);
    // A fresh digit after a result starts a new A and clears the operator.
    dig(4'd7, 15'd7, 1'b0, 3'd0, 2'd0);
  endtask

  task automatic test_overflow();
    do_reset();
    dig(4'd9, 15'd9,    1'b0, 3'd0, 2'd0);
    dig(4'd9, 15'd99,   1'b0, 3'd0, 2'd0);
    dig(4'd9, 15'd999,  1'b0, 3'd0, 2'd0);
    dig(4'd9, 15'd9999, 1'b0, 3'd0, 2'd0);
    opk(2'd1, 15'd9999, 1'b0, 3'd1, 2'd1);
    dig(4'd1, 15'd1,    1'b0, 3'd2, 2'd1);
    eqk(15'd0, 1'b0, 3'd4, 2'd1);
    dig(4'd7, 15'd0, 1'b0, 3'd4, 2'd1);
    opk(2'd2, 15'd0, 1'b0, 3'd4, 2'd1);
    eqk(15'd0, 1'b0, 3'd0, 2'd0);
  endtask

  task automatic test_drop();
    do_reset();
    press(1'b1, 1'b0, 1'b0, 4'd12, 2'd0, 15'd0, 1'b0, 3'd0, 2'd0, "bad_digit");
    press(1'b0, 1'b1, 1'b0, 4'd0,  2'd3, 15'd0, 1'b0, 3'd0, 2'd0, "bad_op3");
    press(1'b0, 1'b1, 1'b0, 4'd0,  2'd0, 15'd0, 1'b0, 3'd0, 2'd0, "bad_op0");
    press(1'b0, 1'b0, 1'b0, 4'd5,  2'd1, 15'd0, 1'b0, 3'd0, 2'd0, "no_flag");
    press(1'b0, 1'b0, 1'b1, 4'd0,  2'd0, 15'd0, 1'b0, 3'd0, 2'd0, "eq_in_A");
    press(1'b1, 1'b1, 1'b1, 4'd6,  2'd1, 15'd6, 1'b0, 3'd0, 2'd0, "num_over_op");
    press(1'b0, 1'b1, 1'b1, 4'd0,  2'd2, 15'd6, 1'b0, 3'd1, 2'd2, "op_over_eq");
    press(1'b0, 1'b0, 1'b1, 4'd0,  2'd0, 15'd6, 1'b0, 3'd1, 2'd2, "eq_in_OP");
    opk(2'd1, 15'd6, 1'b0, 3'd1, 2'd1);
    dig(4'd4, 15'd4, 1'b0, 3'd2, 2'd1);
  endtask

  task automatic test_hold();
    exp_t x;
    do_reset();
    @(negedge clk);
    bus.is_number = 1'b1; bus.is_op = 1'b0; bus.is_eq = 1'b0;
    bus.num_val = 4'd3; bus.op_val = 2'd0;
    bus.key_valid = 1'b1;
    x.mag = 15'd3; x.neg = 1'b0; x.err = 1'b0; x.st = 3'd0; x.op = 2'd0;
    x.due = cyc + 2; x.nm = "hold_first";
    sb.push_back(x);
    repeat (200) @(negedge clk);
    ntot++;
    if (bus.disp_mag !== 15'd3 || bus.state_dbg !== 3'd0) begin
      nbad++;
      $display("FAIL hold_single: got mag=%0d st=%0d want mag=3 st=0", bus.disp_mag, bus.state_dbg);
    end
    bus.key_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    dig(4'd4, 15'd4, 1'b0, 3'd0, 2'd0);
    opk(2'd1, 15'd4, 1'b0, 3'd1, 2'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    ntot++;
    if (bus.disp_mag !== 15'd0 || bus.op_pending !== 2'd0 || bus.state_dbg !== 3'd0 ||
        bus.err !== 1'b0 || bus.disp_neg !== 1'b0) begin
      nbad++;
      $display("FAIL reset_mid: got mag=%0d op=%0d st=%0d want all 0",
               bus.disp_mag, bus.op_pending, bus.state_dbg);
    end
    // Key pressed while reset is asserted must not produce an event afterwards.
    bus.is_number = 1'b1; bus.is_op = 1'b0; bus.is_eq = 1'b0;
    bus.num_val = 4'd7;
    bus.key_valid = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    ntot++;
    if (bus.disp_mag !== 15'd0 || bus.state_dbg !== 3'd0) begin
      nbad++;
      $display("FAIL held_through_reset: got mag=%0d st=%0d want mag=0 st=0",
               bus.disp_mag, bus.state_dbg);
    end
    bus.key_valid = 1'b0;
    repeat (2) @(negedge clk);
    dig(4'd7, 15'd7, 1'b0, 3'd0, 2'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: got no finish want finish before 300us");
    $fatal(1, "timeout");
  end

  initial begin
    cyc = 0; ntot = 0; nbad = 0;
    reset = 1'b1;
    bus.key_valid = 1'b0; bus.is_number = 1'b0; bus.is_op = 1'b0; bus.is_eq = 1'b0;
    bus.num_val = 4'd0; bus.op_val = 2'd0;
    repeat (3) @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_ndig();
    test_chain();
    test_overflow();
    test_drop();
    test_hold();
    test_reset_mid();
    repeat (4) @(negedge clk);
    ntot++;
    if (sb.size() != 0) begin
      nbad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule

`default_nettype wire
